// File: rtl/matmul_stream_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
package matmul_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MAC,
        OUT,
        FIN
    } state_e;

    // Worst-case sum of up to 2**aw products of two dw-bit operands.
    function automatic int unsigned calc_acc_w(input int unsigned dw, input int unsigned aw);
        return 2 * dw + aw;
    endfunction

endpackage

// File: rtl/matmul_stream_if.sv
// Operand and result stream bundle for matmul_stream.
interface matmul_stream_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned RES_W = 16
);
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             out_valid;
    logic [RES_W-1:0] out_data;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matmul_buf.sv
// Single-port synchronous RAM, one-cycle read latency, no reset on contents.
module matmul_buf #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/matmul_stream.sv
// Streaming unsigned matrix multiplier: loads A (d0 x d1) and B (d1 x d2), emits C row-major.
// Define MATMUL_STREAM_SAT_EN to saturate results wider than RES_W and flag them on ovf.
module matmul_stream
    import matmul_stream_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 10,
    parameter int unsigned RES_W = 2 * DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     d0,
    input  logic [DW-1:0]     d1,
    input  logic [DW-1:0]     d2,
    matmul_stream_if.slave    strm,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ovf
);
    localparam int unsigned ACC_W = calc_acc_w(DW, AW);
    localparam int unsigned CW    = (2 * DW > AW + 1) ? 2 * DW : AW + 1;
    localparam int unsigned NW    = AW + 1;

    state_e state_q, state_d;

    logic [DW-1:0]    d0_q, d1_q, d2_q;
    logic [NW-1:0]    na_q, nb_q;
    logic [AW-1:0]    lcnt_q;
    logic [DW-1:0]    i_q, j_q, k_q;
    logic [AW-1:0]    a_row_q, a_ptr_q, b_ptr_q;
    logic             rd_q, rlast_q, fin_q;
    logic [ACC_W-1:0] acc_q;
    logic             err_q;
    logic             out_valid_q, out_last_q;
    logic [RES_W-1:0] out_data_q;

    logic [CW-1:0]    pa, pb;
    logic             dims_bad;
    logic             in_hs, out_hs, a_last, b_last, issue;
    logic [AW-1:0]    a_addr, b_addr;
    logic             a_we, b_we;
    logic [DW-1:0]    a_rdata, b_rdata;
    logic [ACC_W-1:0] prod;
    logic [RES_W-1:0] res;
    logic             sat;

    // Size check is a one-off at job start, outside the address path.
    assign pa       = CW'(d0) * CW'(d1);
    assign pb       = CW'(d1) * CW'(d2);
    assign dims_bad = (d0 == '0) || (d1 == '0) || (d2 == '0) ||
                      (pa > (CW'(1) << AW)) || (pb > (CW'(1) << AW));

    assign strm.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign strm.out_last  = out_last_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == FIN);
    assign err            = err_q;

    assign in_hs  = strm.in_valid && strm.in_ready;
    assign out_hs = out_valid_q && strm.out_ready;
    assign a_last = (lcnt_q == AW'(na_q - NW'(1)));
    assign b_last = (lcnt_q == AW'(nb_q - NW'(1)));
    assign issue  = (state_q == MAC) && (k_q < d1_q);

    assign a_we   = (state_q == LOAD_A) && in_hs;
    assign b_we   = (state_q == LOAD_B) && in_hs;
    assign a_addr = (state_q == MAC) ? a_ptr_q : lcnt_q;
    assign b_addr = (state_q == MAC) ? b_ptr_q : lcnt_q;
    assign prod   = ACC_W'(a_rdata) * ACC_W'(b_rdata);

    matmul_buf #(.DW(DW), .AW(AW)) u_buf_a (
        .clk   (clk),
        .we    (a_we),
        .addr  (a_addr),
        .wdata (strm.in_data),
        .rdata (a_rdata)
    );

    matmul_buf #(.DW(DW), .AW(AW)) u_buf_b (
        .clk   (clk),
        .we    (b_we),
        .addr  (b_addr),
        .wdata (strm.in_data),
        .rdata (b_rdata)
    );

`ifdef MATMUL_STREAM_SAT_EN
    logic ovf_q;

    assign sat = |(acc_q >> RES_W);
    assign res = sat ? '1 : RES_W'(acc_q);
    assign ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == MAC && fin_q) begin
            ovf_q <= sat;
        end else if (out_hs) begin
            ovf_q <= 1'b0;
        end
    end
`else
    assign sat = 1'b0;
    assign res = RES_W'(acc_q);
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !dims_bad) state_d = LOAD_A;
            LOAD_A:  if (in_hs && a_last) state_d = LOAD_B;
            LOAD_B:  if (in_hs && b_last) state_d = MAC;
            MAC:     if (fin_q) state_d = OUT;
            OUT:     if (out_hs) state_d = out_last_q ? FIN : MAC;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            na_q        <= '0;
            nb_q        <= '0;
            lcnt_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_row_q     <= '0;
            a_ptr_q     <= '0;
            b_ptr_q     <= '0;
            rd_q        <= 1'b0;
            rlast_q     <= 1'b0;
            fin_q       <= 1'b0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            err_q   <= 1'b0;
            // Read data lags the address by one cycle; the last flag travels with it.
            rd_q    <= issue;
            rlast_q <= issue && (k_q == d1_q - DW'(1));
            fin_q   <= rd_q && rlast_q;
            if (rd_q) begin
                acc_q <= acc_q + prod;
            end
            if (issue) begin
                k_q     <= k_q + DW'(1);
                a_ptr_q <= a_ptr_q + AW'(1);
                b_ptr_q <= b_ptr_q + AW'(d2_q);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        d0_q   <= d0;
                        d1_q   <= d1;
                        d2_q   <= d2;
                        na_q   <= NW'(pa);
                        nb_q   <= NW'(pb);
                        lcnt_q <= '0;
                        err_q  <= dims_bad;
                    end
                end
                LOAD_A: begin
                    if (in_hs) begin
                        lcnt_q <= a_last ? '0 : lcnt_q + AW'(1);
                    end
                end
                LOAD_B: begin
                    if (in_hs) begin
                        lcnt_q <= lcnt_q + AW'(1);
                        if (b_last) begin
                            i_q     <= '0;
                            j_q     <= '0;
                            k_q     <= '0;
                            a_row_q <= '0;
                            a_ptr_q <= '0;
                            b_ptr_q <= '0;
                            acc_q   <= '0;
                        end
                    end
                end
                MAC: begin
                    if (fin_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= res;
                        out_last_q  <= (i_q == d0_q - DW'(1)) && (j_q == d2_q - DW'(1));
                    end
                end
                OUT: begin
                    if (out_hs) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        k_q         <= '0;
                        acc_q       <= '0;
                        if (j_q == d2_q - DW'(1)) begin
                            j_q     <= '0;
                            i_q     <= i_q + DW'(1);
                            a_row_q <= a_row_q + AW'(d1_q);
                            a_ptr_q <= a_row_q + AW'(d1_q);
                            b_ptr_q <= '0;
                        end else begin
                            j_q     <= j_q + DW'(1);
                            a_ptr_q <= a_row_q;
                            b_ptr_q <= AW'(j_q) + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/matmul_stream.md
MATMUL_STREAM -- requirements
Module: matmul_stream

Interface
REQ-001 SHALL have parameter DW, default 8, element and dimension width.
REQ-002 SHALL have parameter AW, default 10, buffer address width (2**AW elements per operand buffer).
REQ-003 SHALL have parameter RES_W, default 2*DW, result width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port start  in  1  job request, sampled in IDLE only.
REQ-007 SHALL have ports d0, d1, d2  in  DW each  dimensions: A is d0 x d1, B is d1 x d2.
REQ-008 SHALL have ports in_valid  in  1, in_data  in  DW, in_ready  out  1  operand stream.
REQ-009 SHALL have ports out_valid  out  1, out_data  out  RES_W, out_ready  in  1, out_last  out  1  result stream.
REQ-010 SHALL have ports busy  out  1, done  out  1, err  out  1, ovf  out  1.

Function
REQ-011 SHALL use FSM states IDLE, LOAD_A, LOAD_B, MAC, OUT, FIN.
REQ-012 IDLE plus start: SHALL latch d0/d1/d2; if any dim is 0, or d0*d1 > 2**AW, or d1*d2 > 2**AW: err pulses 1 cycle and state stays IDLE; otherwise go to LOAD_A.
REQ-013 start outside IDLE SHALL be ignored.
REQ-014 LOAD_A SHALL assert in_ready; each in_valid&&in_ready beat writes A row-major at addresses 0..d0*d1-1; after the last beat, go to LOAD_B.
REQ-015 LOAD_B SHALL load B row-major at addresses 0..d1*d2-1 the same way; after the last beat, go to MAC with i=j=0.
REQ-016 in_ready SHALL be 0 in all states other than LOAD_A and LOAD_B.
REQ-017 MAC SHALL compute acc = sum over k of A[i*d1+k]*B[k*d2+j] (unsigned), issuing one buffer read pair per cycle; buffer reads are synchronous, 1-cycle latency.
REQ-018 Address generation SHALL use running adders (A pointer +1, B pointer +d2); no multiplier in the address path.
REQ-019 Accumulator width SHALL be ACC_W = 2*DW+AW with no internal wrap.
REQ-020 out_valid SHALL rise exactly d1+2 cycles after MAC entry for element (i,j); state is then OUT.
REQ-021 OUT SHALL hold out_valid, out_data, out_last and ovf stable until out_ready; a handshake advances j, then i, in row-major order and re-enters MAC, or enters FIN after the last element.
REQ-022 out_last SHALL be 1 only with element (d0-1, d2-1).
REQ-023 FIN SHALL pulse done for 1 cycle, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.

Reset
REQ-025 rst low at a clock edge SHALL force IDLE and zero every output (including in_ready and out_valid), abandon any job in progress, and clear all counters; buffer contents are undefined after reset.

Configuration
REQ-026 With MATMUL_STREAM_SAT_EN defined: acc > 2**RES_W-1 SHALL give out_data all ones and ovf=1 for that element.
REQ-027 Without MATMUL_STREAM_SAT_EN: out_data SHALL be acc modulo 2**RES_W and ovf SHALL be tied to 0.

Structure
REQ-028 Package matmul_stream_pkg SHALL hold the FSM state enum and the ACC_W derivation.
REQ-029 Sub-module matmul_buf SHALL be a single-port synchronous RAM, 2**AW x DW, instantiated once for A and once for B.

Verification
REQ-030 Basic: d0=2, d1=5, d2=3, A=1..10, B=1..15, out_ready=1 -> 6 results; first is 135; the 6th has out_last=1; done pulses once.
REQ-031 Backpressure: the same job with out_ready held low for 5 cycles on the first result -> out_data stays 135, out_valid stays 1, and no element is lost or duplicated.
REQ-032 Error: start with d1=0 -> err=1 for 1 cycle, busy stays 0; also start with d0=d1=33 (AW=10) -> err=1.
REQ-033 Overflow: DW=8, d0=d1=d2 set to 1,4,1, all elements 0xFF -> with the macro, out_data=0xFFFF and ovf=1; without it, out_data=0xF804 and ovf=0.
REQ-034 Reset mid-MAC: drive rst low for 1 cycle during the second element -> next cycle busy=0 and out_valid=0; a fresh start then completes correctly.
REQ-035 Input stalls: in_valid toggled 1/0 during load -> only handshaken beats are stored, and the results match REQ-030.
